multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM with memory-wait timeout
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter bit EN_BNE      = 1'b1,
    parameter bit EN_ADDI     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_z,
    input  logic        mem_ready,
    output logic [1:0]  pc_oe,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic [1:0]  imm_oe,
    output logic [1:0]  ext_sel,
    output logic [1:0]  alu_op,
    output logic [2:0]  alu_ctrl,
    output logic        a_wr,
    output logic        b_wr,
    output logic        alu_oe,
    output logic        reg_oe,
    output logic        reg_wr,
    output logic [1:0]  reg_sel,
    output logic        mar_wr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_oe,
    output logic        mdr_src,
    output logic        mdr_oe,
    output logic        mdr_wr,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [4:0]  state
);
    typedef enum logic [4:0] {
        S_IF0, S_IF1, S_IF2, S_IF3, S_ID, S_MA0, S_MA1, S_LW2, S_LW3, S_SW2, S_SW3,
        S_R0, S_R1, S_AI0, S_AI1, S_B0, S_B1, S_B2, S_B3, S_B4, S_JP, S_ERR
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam int CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int TO_M1 = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_t        cur;
    state_t        id_next;
    logic          started;
    logic [5:0]    opcode;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          taken;
    logic          instr_unused;

    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: dispatch = S_MA0;
            OP_R:         dispatch = S_R0;
            OP_ADDI:      dispatch = EN_ADDI ? S_AI0 : S_ERR;
            OP_BEQ:       dispatch = S_B0;
            OP_BNE:       dispatch = EN_BNE ? S_B0 : S_ERR;
            OP_J:         dispatch = S_JP;
            default:      dispatch = S_ERR;
        endcase
    endfunction

    assign instr_unused = ^instr[25:0];
    assign id_next      = dispatch(opcode);
    assign timeout_hit  = (MEM_TIMEOUT > 0) && (wait_cnt == CW'(TO_M1));
    assign taken        = (opcode == OP_BNE) ? ~alu_z : alu_z;
    assign state        = cur;

    // started holds outputs quiet for the first edge after reset so IF0 begins on that edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= S_IF0;
            started     <= 1'b0;
            opcode      <= 6'd0;
            wait_cnt    <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
        end else begin
            case (cur)
                S_IF0: cur <= S_IF1;
                S_IF1: begin
                    if (mem_ready) begin
                        opcode   <= instr[31:26];
                        cur      <= S_IF2;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        cur         <= S_ERR;
                        mem_timeout <= 1'b1;
                        wait_cnt    <= '0;
                    end else if (MEM_TIMEOUT > 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_IF2: cur <= S_IF3;
                S_IF3: cur <= S_ID;
                S_ID: begin
                    cur <= id_next;
                    if (id_next == S_ERR) illegal_op <= 1'b1;
                end
                S_MA0: cur <= S_MA1;
                S_MA1: cur <= (opcode == OP_LW) ? S_LW2 : S_SW2;
                S_LW2: begin
                    if (mem_ready) begin
                        cur      <= S_LW3;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        cur         <= S_ERR;
                        mem_timeout <= 1'b1;
                        wait_cnt    <= '0;
                    end else if (MEM_TIMEOUT > 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_LW3: cur <= S_IF0;
                S_SW2: cur <= S_SW3;
                S_SW3: begin
                    if (mem_ready) begin
                        cur      <= S_IF0;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        cur         <= S_ERR;
                        mem_timeout <= 1'b1;
                        wait_cnt    <= '0;
                    end else if (MEM_TIMEOUT > 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_R0:  cur <= S_R1;
                S_R1:  cur <= S_IF0;
                S_AI0: cur <= S_AI1;
                S_AI1: cur <= S_IF0;
                S_B0:  cur <= S_B1;
                S_B1:  cur <= taken ? S_B2 : S_IF0;
                S_B2:  cur <= S_B3;
                S_B3:  cur <= S_B4;
                S_B4:  cur <= S_IF0;
                S_JP:  cur <= S_IF0;
                S_ERR: cur <= S_ERR;
                default: cur <= S_ERR;
            endcase
        end
    end

    always_comb begin
        pc_oe    = 2'b00;
        pc_wr    = 1'b0;
        ir_wr    = 1'b0;
        imm_oe   = 2'b00;
        ext_sel  = 2'b00;
        alu_op   = 2'b00;
        alu_ctrl = 3'b000;
        a_wr     = 1'b0;
        b_wr     = 1'b0;
        alu_oe   = 1'b0;
        reg_oe   = 1'b0;
        reg_wr   = 1'b0;
        reg_sel  = 2'b00;
        mar_wr   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_oe   = 1'b0;
        mdr_src  = 1'b0;
        mdr_oe   = 1'b0;
        mdr_wr   = 1'b0;
        if (started) begin
            case (cur)
                S_IF0: begin pc_oe = 2'b11; mar_wr = 1'b1; a_wr = 1'b1; end
                S_IF1: begin mem_rd = 1'b1; mem_oe = 1'b1; ir_wr = mem_ready; end
                S_IF2: begin ext_sel = 2'b10; imm_oe = 2'b11; b_wr = 1'b1; end
                S_IF3: begin alu_ctrl = 3'b100; alu_oe = 1'b1; pc_wr = 1'b1; end
                S_ID:  begin reg_sel = 2'b00; reg_oe = 1'b1; a_wr = 1'b1; end
                S_MA0, S_AI0: begin ext_sel = 2'b00; imm_oe = 2'b11; b_wr = 1'b1; end
                S_MA1: begin alu_ctrl = 3'b100; alu_oe = 1'b1; mar_wr = 1'b1; end
                S_LW2: begin mem_rd = 1'b1; mdr_src = 1'b1; mdr_wr = mem_ready; end
                S_LW3: begin mdr_oe = 1'b1; reg_sel = 2'b01; reg_wr = 1'b1; end
                S_SW2: begin reg_sel = 2'b01; reg_oe = 1'b1; mdr_wr = 1'b1; end
                S_SW3: mem_wr = 1'b1;
                S_R0, S_B0: begin reg_sel = 2'b01; reg_oe = 1'b1; b_wr = 1'b1; end
                S_R1:  begin alu_op = 2'b10; alu_oe = 1'b1; reg_sel = 2'b10; reg_wr = 1'b1; end
                S_AI1: begin alu_ctrl = 3'b100; alu_oe = 1'b1; reg_sel = 2'b01; reg_wr = 1'b1; end
                S_B1:  begin alu_ctrl = 3'b110; alu_op = 2'b01; end
                S_B2:  begin pc_oe = 2'b11; a_wr = 1'b1; end
                S_B3:  begin ext_sel = 2'b01; imm_oe = 2'b11; b_wr = 1'b1; end
                S_B4:  begin alu_ctrl = 3'b100; alu_oe = 1'b1; pc_wr = 1'b1; end
                S_JP:  begin pc_oe = 2'b10; ext_sel = 2'b11; imm_oe = 2'b01; pc_wr = 1'b1; end
                default: ;
            endcase
        end
    end
endmodule
